// File: rtl/control_unit.sv
// Fetch/execute sequencer that drives every datapath strobe from the registered state and IR.
// Optional CTRL_MEMWAIT_EN adds Mem_ready and stretches memory steps until it is sampled high.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
`ifdef CTRL_MEMWAIT_EN
    input  logic        Mem_ready,
`endif
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
    output logic        Yin, ZHighin, ZLowin, ZHighout, ZLowout,
    output logic        HIin, HIout, LOin, LOout, Cout, InPort, OutPort,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        CON_in, Read, Write,
    output logic [4:0]  OP,
    output logic        Run
);

    localparam logic [4:0] OPC_LD   = 5'd0,  OPC_LDI  = 5'd1,  OPC_ST   = 5'd2;
    localparam logic [4:0] OPC_MUL  = 5'd15, OPC_DIV  = 5'd16, OPC_NEG  = 5'd17;
    localparam logic [4:0] OPC_NOT  = 5'd18, OPC_BR   = 5'd19, OPC_JR   = 5'd20;
    localparam logic [4:0] OPC_IN   = 5'd22, OPC_OUT  = 5'd23, OPC_MFHI = 5'd24;
    localparam logic [4:0] OPC_MFLO = 5'd25, OPC_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state, state_next, boundary;
    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic [2:0] exec_len;
    logic       is_rtype, is_imm, is_unary, is_muldiv, is_mem;
    logic       mem_ok;
    logic       ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];
    assign is_rtype  = (opcode >= 5'd3) && (opcode <= 5'd11);
    assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
    assign is_unary  = (opcode == OPC_NEG) || (opcode == OPC_NOT);
    assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
    assign is_mem    = (opcode <= OPC_ST);
    // Stop is only consulted where an instruction would hand back to fetch.
    assign boundary  = Stop ? S_HALT : S_T0;

`ifdef CTRL_MEMWAIT_EN
    assign mem_ok = Mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        exec_len = 3'd0;
        if (is_rtype || is_imm || opcode == OPC_LDI)
            exec_len = 3'd3;
        else if (is_muldiv || opcode == OPC_BR)
            exec_len = 3'd4;
        else if (opcode == OPC_LD || opcode == OPC_ST)
            exec_len = 3'd5;
        else if (is_unary)
            exec_len = 3'd2;
        else if (opcode inside {OPC_JR, OPC_IN, OPC_OUT, OPC_MFHI, OPC_MFLO})
            exec_len = 3'd1;
    end

    always_comb begin
        alu_op = 5'b00000;
        case (opcode)
            5'd4:        alu_op = 5'b00001;
            5'd5, 5'd13: alu_op = 5'b00100;
            5'd6, 5'd14: alu_op = 5'b00101;
            5'd7:        alu_op = 5'b00110;
            5'd8:        alu_op = 5'b00111;
            5'd9:        alu_op = 5'b01000;
            5'd10:       alu_op = 5'b01001;
            5'd11:       alu_op = 5'b01010;
            OPC_MUL:     alu_op = 5'b01011;
            OPC_DIV:     alu_op = 5'b01100;
            OPC_NEG:     alu_op = 5'b00011;
            OPC_NOT:     alu_op = 5'b00010;
            default:     alu_op = 5'b00000;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            state <= S_RESET;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = boundary;
            S_T0:    state_next = S_T1;
            S_T1:    if (mem_ok) state_next = S_T2;
            S_T2: begin
                if (opcode == OPC_HALT)
                    state_next = S_HALT;
                else
                    state_next = (exec_len == 3'd0) ? boundary : S_T3;
            end
            S_T3:    state_next = (exec_len == 3'd1) ? boundary : S_T4;
            S_T4:    state_next = (exec_len == 3'd2) ? boundary : S_T5;
            S_T5:    state_next = (exec_len == 3'd3) ? boundary : S_T6;
            S_T6:    if (opcode != OPC_LD || mem_ok)
                         state_next = (exec_len == 3'd4) ? boundary : S_T7;
            S_T7:    if (opcode != OPC_ST || mem_ok) state_next = boundary;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; ZHighin = 1'b0; ZLowin = 1'b0;
        ZHighout = 1'b0; ZLowout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0;
        LOout = 1'b0; Cout = 1'b0; InPort = 1'b0; OutPort = 1'b0; Gra = 1'b0;
        Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        CON_in = 1'b0; Read = 1'b0; Write = 1'b0; OP = 5'b00000;
        Run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_rtype || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; OP = alu_op; ZLowin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else begin
                    case (opcode)
                        OPC_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
                        OPC_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OPC_IN:   begin InPort = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OPC_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
                        OPC_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OPC_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            S_T4: begin
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; OP = alu_op; ZLowin = 1'b1;
                end else if (is_imm || is_mem) begin
                    Cout = 1'b1; OP = alu_op; ZLowin = 1'b1;
                end else if (is_unary) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; OP = alu_op; ZHighin = 1'b1; ZLowin = 1'b1;
                end else if (opcode == OPC_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_rtype || is_imm || opcode == OPC_LDI) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    ZLowout = 1'b1; LOin = 1'b1;
                end else if (opcode == OPC_LD || opcode == OPC_ST) begin
                    ZLowout = 1'b1; MARin = 1'b1;
                end else if (opcode == OPC_BR) begin
                    Cout = 1'b1; OP = alu_op; ZLowin = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                end else if (opcode == OPC_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (opcode == OPC_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (opcode == OPC_BR && CON_FF) begin
                    ZLowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OPC_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OPC_ST) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model predicts every strobe each cycle.
// Build with CTRL_MEMWAIT_EN defined to exercise the Mem_ready stall cases as well.
`timescale 1ns/1ps
module tb_control_unit;

    typedef logic [33:0] vec_t;

    localparam vec_t M_RUN      = 34'd1 << 5;
    localparam vec_t M_PCOUT    = 34'd1 << 6;
    localparam vec_t M_PCIN     = 34'd1 << 7;
    localparam vec_t M_INCPC    = 34'd1 << 8;
    localparam vec_t M_MARIN    = 34'd1 << 9;
    localparam vec_t M_MDRIN    = 34'd1 << 10;
    localparam vec_t M_MDROUT   = 34'd1 << 11;
    localparam vec_t M_IRIN     = 34'd1 << 12;
    localparam vec_t M_YIN      = 34'd1 << 13;
    localparam vec_t M_ZHIGHIN  = 34'd1 << 14;
    localparam vec_t M_ZLOWIN   = 34'd1 << 15;
    localparam vec_t M_ZHIGHOUT = 34'd1 << 16;
    localparam vec_t M_ZLOWOUT  = 34'd1 << 17;
    localparam vec_t M_HIIN     = 34'd1 << 18;
    localparam vec_t M_HIOUT    = 34'd1 << 19;
    localparam vec_t M_LOIN     = 34'd1 << 20;
    localparam vec_t M_LOOUT    = 34'd1 << 21;
    localparam vec_t M_COUT     = 34'd1 << 22;
    localparam vec_t M_INPORT   = 34'd1 << 23;
    localparam vec_t M_OUTPORT  = 34'd1 << 24;
    localparam vec_t M_GRA      = 34'd1 << 25;
    localparam vec_t M_GRB      = 34'd1 << 26;
    localparam vec_t M_GRC      = 34'd1 << 27;
    localparam vec_t M_RIN      = 34'd1 << 28;
    localparam vec_t M_ROUT     = 34'd1 << 29;
    localparam vec_t M_BAOUT    = 34'd1 << 30;
    localparam vec_t M_CONIN    = 34'd1 << 31;
    localparam vec_t M_READ     = 34'd1 << 32;
    localparam vec_t M_WRITE    = 34'd1 << 33;

    logic        Clock, Clear, CON_FF, Stop;
    logic [31:0] IR;
`ifdef CTRL_MEMWAIT_EN
    logic        Mem_ready;
`endif
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic Yin, ZHighin, ZLowin, ZHighout, ZLowout;
    logic HIin, HIout, LOin, LOout, Cout, InPort, OutPort;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Read, Write, Run;
    logic [4:0] OP;

    vec_t  obs;
    vec_t  plan_v[$];
    bit    plan_m[$];
    vec_t  exp_v[$];
    int    exp_i[$];
    string cur_name;
    int    cyc_idx;
    int    n_checks = 0;
    int    n_fail = 0;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
`ifdef CTRL_MEMWAIT_EN
        .Mem_ready(Mem_ready),
`endif
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin), .ZLowin(ZLowin),
        .ZHighout(ZHighout), .ZLowout(ZLowout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .Cout(Cout), .InPort(InPort), .OutPort(OutPort),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CON_in(CON_in), .Read(Read), .Write(Write), .OP(OP), .Run(Run)
    );

    assign obs = {Write, Read, CON_in, BAout, Rout, Rin, Grc, Grb, Gra, OutPort, InPort,
                  Cout, LOout, LOin, HIout, HIin, ZLowout, ZHighout, ZLowin, ZHighin,
                  Yin, IRin, MDRout, MDRin, MARin, IncPC, PCin, PCout, Run, OP};

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input vec_t act, input vec_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Compare process: every cycle that has a model prediction is checked mid-cycle.
    always @(negedge Clock) begin
        if (exp_v.size() > 0) begin
            vec_t e;
            int   i;
            e = exp_v.pop_front();
            i = exp_i.pop_front();
            checkOutput($sformatf("%s_cycle%0d", cur_name, i), obs, e);
        end
    end

    function automatic vec_t alu_of(input logic [4:0] opc);
        case (opc)
            5'd4:         return vec_t'(5'b00001);
            5'd5, 5'd13:  return vec_t'(5'b00100);
            5'd6, 5'd14:  return vec_t'(5'b00101);
            5'd7:         return vec_t'(5'b00110);
            5'd8:         return vec_t'(5'b00111);
            5'd9:         return vec_t'(5'b01000);
            5'd10:        return vec_t'(5'b01001);
            5'd11:        return vec_t'(5'b01010);
            5'd15:        return vec_t'(5'b01011);
            5'd16:        return vec_t'(5'b01100);
            5'd17:        return vec_t'(5'b00011);
            5'd18:        return vec_t'(5'b00010);
            default:      return vec_t'(5'b00000);
        endcase
    endfunction

    task automatic add_step(input vec_t v);
        plan_v.push_back(v | M_RUN);
        plan_m.push_back(1'b1);
    endtask

    task automatic add_mem_step(input vec_t v, input int stall);
        for (int k = 0; k < stall; k++) begin
            plan_v.push_back(v | M_RUN);
            plan_m.push_back(1'b0);
        end
        add_step(v);
    endtask

    // Instruction-level model: the cycle-by-cycle strobe list for one whole instruction.
    task automatic build_plan(input logic [31:0] ir_val, input bit con, input int stall);
        logic [4:0] opc;
        vec_t       a;
        opc = ir_val[31:27];
        a   = alu_of(opc);
        plan_v.delete();
        plan_m.delete();
        add_step(M_PCOUT | M_MARIN | M_INCPC);
        add_step(M_PCIN | M_READ | M_MDRIN);
        add_step(M_MDROUT | M_IRIN);
        if (opc >= 5'd3 && opc <= 5'd14) begin
            add_step(M_GRB | M_ROUT | M_YIN);
            if (opc <= 5'd11) add_step(M_GRC | M_ROUT | M_ZLOWIN | a);
            else              add_step(M_COUT | M_ZLOWIN | a);
            add_step(M_ZLOWOUT | M_GRA | M_RIN);
        end else if (opc == 5'd17 || opc == 5'd18) begin
            add_step(M_GRB | M_ROUT | M_ZLOWIN | a);
            add_step(M_ZLOWOUT | M_GRA | M_RIN);
        end else if (opc == 5'd15 || opc == 5'd16) begin
            add_step(M_GRA | M_ROUT | M_YIN);
            add_step(M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN | a);
            add_step(M_ZLOWOUT | M_LOIN);
            add_step(M_ZHIGHOUT | M_HIIN);
        end else if (opc <= 5'd2) begin
            add_step(M_GRB | M_BAOUT | M_YIN);
            add_step(M_COUT | M_ZLOWIN);
            if (opc == 5'd1) begin
                add_step(M_ZLOWOUT | M_GRA | M_RIN);
            end else begin
                add_step(M_ZLOWOUT | M_MARIN);
                if (opc == 5'd0) begin
                    add_mem_step(M_READ | M_MDRIN, stall);
                    add_step(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    add_step(M_GRA | M_ROUT | M_MDRIN);
                    add_mem_step(M_WRITE, stall);
                end
            end
        end else if (opc == 5'd19) begin
            add_step(M_GRA | M_ROUT | M_CONIN);
            add_step(M_PCOUT | M_YIN);
            add_step(M_COUT | M_ZLOWIN);
            add_step(con ? (M_ZLOWOUT | M_PCIN) : '0);
        end else begin
            case (opc)
                5'd20: add_step(M_GRA | M_ROUT | M_PCIN);
                5'd22: add_step(M_INPORT | M_GRA | M_RIN);
                5'd23: add_step(M_GRA | M_ROUT | M_OUTPORT);
                5'd24: add_step(M_HIOUT | M_GRA | M_RIN);
                5'd25: add_step(M_LOOUT | M_GRA | M_RIN);
                default: ;
            endcase
        end
    endtask

    // Called just after a rising edge with the DUT in T0.
    task automatic applyStimulus(input string name, input logic [31:0] ir_val,
                                 input bit con, input bit stop_req, input int stall);
        cur_name = name;
        cyc_idx  = 0;
        IR       = ir_val;
        CON_FF   = con;
        Stop     = stop_req;
        build_plan(ir_val, con, stall);
    endtask

    task automatic step_cycle();
        vec_t v;
        bit   m;
        v = plan_v.pop_front();
        m = plan_m.pop_front();
`ifdef CTRL_MEMWAIT_EN
        Mem_ready = m;
`else
        if (m) cyc_idx = cyc_idx + 0;
`endif
        exp_v.push_back(v);
        exp_i.push_back(cyc_idx);
        cyc_idx++;
        @(posedge Clock);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step_cycle();
    endtask

    task automatic finish_instr();
        while (plan_v.size() > 0) step_cycle();
        Stop = 1'b0;
    endtask

    task automatic expect_idle(input string name, input int n);
        cur_name = name;
        for (int k = 0; k < n; k++) begin
            exp_v.push_back('0);
            exp_i.push_back(k);
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic reset_dut(input string name);
        Clear = 1'b0;
        #1 checkOutput({name, "_clear_async"}, obs, '0);
        @(posedge Clock);
        #1 checkOutput({name, "_reset_hold"}, obs, '0);
        Clear = 1'b1;
        @(posedge Clock);
        #1 checkOutput({name, "_first_t0"}, vec_t'({PCout, MARin, IncPC, Run}), vec_t'(4'b1111));
    endtask

    initial begin
        Clock = 1'b0; Clear = 1'b1; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
        cur_name = "init"; cyc_idx = 0;
`ifdef CTRL_MEMWAIT_EN
        Mem_ready = 1'b1;
`endif
        #2;
        reset_dut("power_on");

        applyStimulus("add", 32'h18918000, 1'b0, 1'b0, 0);
        step_n(3);
        checkOutput("add_t3", vec_t'({Grb, Rout, Yin, ZLowin}), vec_t'(4'b1110));
        step_n(1);
        checkOutput("add_t4", vec_t'({Grc, Rout, ZLowin, Yin}), vec_t'(4'b1110));
        checkOutput("add_t4_op", vec_t'(OP), vec_t'(5'b00000));
        step_n(1);
        checkOutput("add_t5", vec_t'({ZLowout, Gra, Rin, Rout}), vec_t'(4'b1110));
        finish_instr();
        checkOutput("add_next_t0", vec_t'({PCout, MARin, IncPC}), vec_t'(3'b111));

        applyStimulus("not", 32'h90080000, 1'b0, 1'b0, 0);
        step_n(3);
        checkOutput("not_t3", vec_t'({Grb, Rout, ZLowin, Yin}), vec_t'(4'b1110));
        checkOutput("not_t3_op", vec_t'(OP), vec_t'(5'b00010));
        step_n(1);
        checkOutput("not_t4", vec_t'({ZLowout, Gra, Rin}), vec_t'(3'b111));
        finish_instr();
        checkOutput("not_next_t0", vec_t'({PCout, MARin, IncPC}), vec_t'(3'b111));

        applyStimulus("br_not_taken", {5'd19, 27'h0400000}, 1'b0, 1'b0, 0);
        step_n(6);
        checkOutput("br0_t6", vec_t'({PCin, ZLowout, Run}), vec_t'(3'b001));
        finish_instr();
        applyStimulus("br_taken", {5'd19, 27'h0400000}, 1'b1, 1'b0, 0);
        step_n(6);
        checkOutput("br1_t6", vec_t'({PCin, ZLowout, Run}), vec_t'(3'b111));
        finish_instr();

        applyStimulus("mul", {5'd15, 27'h0123456}, 1'b0, 1'b0, 0);
        step_n(4);
        checkOutput("mul_t4_op", vec_t'(OP), vec_t'(5'b01011));
        finish_instr();

        for (int o = 0; o < 32; o++) begin
            logic [4:0] oc;
            oc = o[4:0];
            if (oc != 5'd27) begin
                applyStimulus($sformatf("opc%0d", o), {oc, 27'h2A5A5A5}, o[0], 1'b0, 0);
                finish_instr();
            end
        end

        applyStimulus("sub_abort", {5'd4, 27'h0}, 1'b0, 1'b0, 0);
        step_n(4);
        #1;
        plan_v.delete();
        plan_m.delete();
        reset_dut("abort");

`ifdef CTRL_MEMWAIT_EN
        applyStimulus("ld_wait", {5'd0, 27'h0080000}, 1'b0, 1'b0, 3);
        step_n(6);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("ld_wait_t6_%0d", k), vec_t'({Read, MDRin}), vec_t'(2'b11));
            step_n(1);
        end
        checkOutput("ld_wait_t7", vec_t'({MDRout, Gra, Rin, Read}), vec_t'(4'b1110));
        finish_instr();
        applyStimulus("st_wait", {5'd2, 27'h0080000}, 1'b0, 1'b0, 2);
        finish_instr();
        applyStimulus("ld_ready", {5'd0, 27'h0}, 1'b0, 1'b0, 0);
        finish_instr();
`endif

        applyStimulus("add_stop", 32'h18918000, 1'b0, 1'b1, 0);
        finish_instr();
        expect_idle("stop_halt", 22);
        checkOutput("stop_run_low", vec_t'({Run, PCout}), vec_t'(2'b00));
        reset_dut("after_stop");

        applyStimulus("halt", {5'd27, 27'h0}, 1'b0, 1'b0, 0);
        finish_instr();
        expect_idle("halt_idle", 22);
        checkOutput("halt_run_low", vec_t'({Run, PCout, IRin}), vec_t'(3'b000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
